// File: rtl/mold_pkg.sv
// mold_pkg: shared MoldUDP64 widths and reassembler state encoding
package mold_pkg;
    localparam int AXI_DATA_W    = 64;
    localparam int ML_W          = 16;
    localparam int MSG_MAX_BYTES = 64;
    typedef enum logic [1:0] {IDLE, ASM, DROP} state_t;
endpackage

// File: rtl/mold_popcnt.sv
// mold_popcnt: combinational count of set bits in a byte-enable mask
module mold_popcnt #(
    parameter int N = 8
) (
    input  logic [N-1:0]             mask,
    output logic [$clog2(N+1)-1:0]   cnt
);
    localparam int CW = $clog2(N + 1);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + CW'(mask[i]);
    end
endmodule

// File: rtl/mold_msg_reasm.sv
// mold_msg_reasm: packs MoldUDP64 message beats into one wide message word
module mold_msg_reasm #(
    parameter int AXI_DATA_W    = mold_pkg::AXI_DATA_W,
    parameter int ML_W          = mold_pkg::ML_W,
    parameter int MSG_MAX_BYTES = mold_pkg::MSG_MAX_BYTES
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       mold_msg_v_i,
    input  logic                       mold_msg_start_i,
    input  logic [ML_W-1:0]            mold_msg_len_i,
    input  logic [AXI_DATA_W/8-1:0]    mold_msg_mask_i,
    input  logic [AXI_DATA_W-1:0]      mold_msg_data_i,
    output logic                       msg_v_o,
    output logic [ML_W-1:0]            msg_len_o,
    output logic [8*MSG_MAX_BYTES-1:0] msg_data_o,
    output logic                       msg_err_o
);
    import mold_pkg::*;
    localparam int NB = AXI_DATA_W / 8;
    localparam int CW = $clog2(NB + 1);
    localparam int MB = MSG_MAX_BYTES;
    state_t state;
    logic [ML_W-1:0] len_q, cnt, len_eff, cnt_base;
    logic [ML_W:0] sum;
    logic [CW-1:0] pc;
    logic [MB-1:0] en;
    logic [8*MB-1:0] buf_q, buf_nxt, wide, bm;
    logic start_v, act, done, big, emit, err;

    mold_popcnt #(.N(NB)) u_popcnt (.mask(mold_msg_mask_i), .cnt(pc));

    always_comb begin
        start_v  = mold_msg_v_i && mold_msg_start_i;
        act      = mold_msg_v_i && (mold_msg_start_i || state != IDLE);
        len_eff  = start_v ? mold_msg_len_i : len_q;
        cnt_base = start_v ? '0 : cnt;
        sum      = {1'b0, cnt_base} + (ML_W+1)'(pc);
        done     = sum >= {1'b0, len_eff};
        big      = int'(len_eff) > MB;
        emit     = act && done && !big && len_eff != '0;
        err      = (start_v && state == ASM) || (act && done && (big || len_eff == '0));
        // byte enables land at the running offset and are clipped at len
        en       = (act && !big) ? MB'(mold_msg_mask_i) << cnt_base : '0;
        for (int j = 0; j < MB; j++) if (j >= int'(len_eff)) en[j] = 1'b0;
        wide     = (8*MB)'(mold_msg_data_i) << {cnt_base, 3'b000};
        bm       = '0;
        for (int j = 0; j < MB; j++) bm[j*8 +: 8] = {8{en[j]}};
        buf_nxt  = ((start_v ? '0 : buf_q) & ~bm) | (wide & bm);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt        <= '0;
            buf_q      <= '0;
            msg_v_o    <= 1'b0;
            msg_err_o  <= 1'b0;
            msg_len_o  <= '0;
            msg_data_o <= '0;
        end else begin
            msg_v_o   <= emit;
            msg_err_o <= err;
            buf_q     <= buf_nxt;
            if (act) begin
                state <= done ? IDLE : big ? DROP : ASM;
                len_q <= len_eff;
                cnt   <= done ? len_eff : sum[ML_W-1:0];
            end
            if (emit) begin
                msg_len_o  <= len_eff;
                msg_data_o <= buf_nxt;
            end
        end
    end
endmodule

// File: tb/tb_mold_msg_reasm.sv
// tb_mold_msg_reasm: directed checks of message reassembly, drop and truncation
module tb_mold_msg_reasm;
    localparam int DW = 64, LW = 16, MB = 64, NB = DW / 8;
    logic clk = 1'b0, nreset = 1'b0, v = 1'b0, st = 1'b0;
    logic [LW-1:0] len = '0;
    logic [NB-1:0] mask = '0;
    logic [DW-1:0] data = '0;
    logic msg_v, msg_err;
    logic [LW-1:0] msg_len;
    logic [8*MB-1:0] msg_data;
    int checks = 0, errors = 0, v_cnt = 0, e_cnt = 0, v0 = 0, e0 = 0;

    mold_msg_reasm dut (
        .clk(clk), .nreset(nreset),
        .mold_msg_v_i(v), .mold_msg_start_i(st), .mold_msg_len_i(len),
        .mold_msg_mask_i(mask), .mold_msg_data_i(data),
        .msg_v_o(msg_v), .msg_len_o(msg_len), .msg_data_o(msg_data), .msg_err_o(msg_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (msg_v) v_cnt++;
        if (msg_err) e_cnt++;
    end

    task automatic chk(input string tag, input logic [8*MB-1:0] got, input logic [8*MB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*MB-1:0] mk(input int n, input int base);
        logic [8*MB-1:0] r = '0;
        for (int k = 0; k < n; k++) r[k*8 +: 8] = 8'(base + k);
        return r;
    endfunction

    function automatic logic [DW-1:0] bd(input int base, input int off, input logic [NB-1:0] m);
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = m[i] ? 8'(base + off + i) : 8'hEE;
        return r;
    endfunction

    task automatic send(input logic s, input int l, input logic [NB-1:0] m, input logic [DW-1:0] d);
        v = 1'b1; st = s; len = LW'(l); mask = m; data = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        v = 1'b0; st = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v", msg_v, 0);
        chk("rst_err", msg_err, 0);
        chk("rst_len", msg_len, 0);
        chk("rst_data", msg_data, 0);
        nreset = 1'b1;
        idle(1);

        send(1, 16, 8'hFF, bd(8'h10, 0, 8'hFF));
        chk("s1_first_v", msg_v, 0);
        send(0, 0, 8'hFF, bd(8'h10, 8, 8'hFF));
        chk("s1_v", msg_v, 1);
        chk("s1_len", msg_len, 16);
        chk("s1_data", msg_data, mk(16, 8'h10));
        idle(1);
        chk("s1_one_pulse", msg_v, 0);

        send(1, 10, 8'hFF, bd(8'h20, 0, 8'hFF));
        send(0, 0, 8'h0F, bd(8'h20, 8, 8'h0F));
        chk("s2_v", msg_v, 1);
        chk("s2_len", msg_len, 10);
        chk("s2_data", msg_data, mk(10, 8'h20));
        idle(1);

        send(1, 4, 8'h0F, bd(8'h30, 0, 8'h0F));
        chk("s3a_v", msg_v, 1);
        chk("s3a_data", msg_data, mk(4, 8'h30));
        send(1, 8, 8'hFF, bd(8'h40, 0, 8'hFF));
        chk("s3b_v", msg_v, 1);
        chk("s3b_len", msg_len, 8);
        chk("s3b_data", msg_data, mk(8, 8'h40));
        idle(1);

        v0 = v_cnt; e0 = e_cnt;
        send(1, 100, 8'hFF, bd(0, 0, 8'hFF));
        for (int b = 1; b <= 13; b++) begin
            send(0, 0, 8'hFF, bd(0, 8 * b, 8'hFF));
            if (b == 12) chk("s4_err_at_end", msg_err, 1);
        end
        idle(2);
        chk("s4_err_once", e_cnt - e0, 1);
        chk("s4_no_v", v_cnt - v0, 0);
        chk("s4_len_held", msg_len, 8);
        chk("s4_data_held", msg_data, mk(8, 8'h40));

        send(1, 24, 8'hFF, bd(8'h50, 0, 8'hFF));
        send(0, 0, 8'hFF, bd(8'h50, 8, 8'hFF));
        chk("s5_mid_err", msg_err, 0);
        send(1, 8, 8'hFF, bd(8'h60, 0, 8'hFF));
        chk("s5_trunc_err", msg_err, 1);
        chk("s5_v", msg_v, 1);
        chk("s5_len", msg_len, 8);
        chk("s5_data", msg_data, mk(8, 8'h60));
        idle(1);

        send(1, 0, 8'hFF, bd(8'h90, 0, 8'hFF));
        chk("zero_err", msg_err, 1);
        chk("zero_v", msg_v, 0);
        idle(1);
        send(0, 0, 8'hFF, bd(8'h99, 0, 8'hFF));
        chk("stray_v", msg_v, 0);
        chk("stray_err", msg_err, 0);
        idle(1);

        send(1, 24, 8'hFF, bd(8'h70, 0, 8'hFF));
        send(0, 0, 8'hFF, bd(8'h70, 8, 8'hFF));
        v = 1'b0;
        v0 = v_cnt; e0 = e_cnt;
        #2 nreset = 1'b0;
        #1;
        chk("mrst_v", msg_v, 0);
        chk("mrst_err", msg_err, 0);
        chk("mrst_len", msg_len, 0);
        chk("mrst_data", msg_data, 0);
        idle(2);
        nreset = 1'b1;
        send(0, 0, 8'hFF, bd(8'h70, 16, 8'hFF));
        idle(2);
        chk("mrst_no_v", v_cnt - v0, 0);
        chk("mrst_no_err", e_cnt - e0, 0);
        send(1, 16, 8'hFF, bd(8'h80, 0, 8'hFF));
        send(0, 0, 8'hFF, bd(8'h80, 8, 8'hFF));
        chk("post_v", msg_v, 1);
        chk("post_len", msg_len, 16);
        chk("post_data", msg_data, mk(16, 8'h80));
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
